// File: rtl/regfile_alu_pipe_pkg.sv
// Shared opcode, width-default and state encodings for the regfile ALU execution stage.
package regfile_alu_pipe_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_REG_WIDTH  = 5;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOP = 3'd0;
  localparam op_t OP_ADD = 3'd1;
  localparam op_t OP_SUB = 3'd2;
  localparam op_t OP_AND = 3'd3;
  localparam op_t OP_OR  = 3'd4;
  localparam op_t OP_XOR = 3'd5;
  localparam op_t OP_LDI = 3'd6;
  localparam op_t OP_MOV = 3'd7;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_alu_pipe_alu_core.sv
// Combinational ALU: op/a/b -> result, zero latency, no flow control.
// LDI returns b (the caller routes the immediate there); MOV returns a.
module alu_core
  import regfile_alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = b;
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Execution stage over a read-first 2R1W register file; clears the file after reset.
// Accept-to-write latency 2 cycles, 1 instr/cycle, instr_ready only gates during INIT.
module regfile_alu_pipe
  import regfile_alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [REG_WIDTH-1:0]  instr_rd,
  input  logic [REG_WIDTH-1:0]  instr_rs1,
  input  logic [REG_WIDTH-1:0]  instr_rs2,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [REG_WIDTH-1:0]  rf_rd_addr1,
  output logic [REG_WIDTH-1:0]  rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  output logic [REG_WIDTH-1:0]  rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wen,
  output logic                  init_done
);

  typedef struct packed {
    logic [2:0]            op;
    logic [REG_WIDTH-1:0]  rd;
    logic [REG_WIDTH-1:0]  rs1;
    logic [REG_WIDTH-1:0]  rs2;
    logic [DATA_WIDTH-1:0] imm;
  } s1_t;

  logic [0:0]            state;
  logic [REG_WIDTH-1:0]  init_cnt;
  logic                  s1_valid;
  s1_t                   s1;
  logic                  wb_valid;
  logic                  wb_wen;
  logic [REG_WIDTH-1:0]  wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  lw_valid;
  logic [REG_WIDTH-1:0]  lw_addr;
  logic [DATA_WIDTH-1:0] lw_data;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  accept;

  assign instr_ready = (state == ST_RUN);
  assign init_done   = (state == ST_RUN);
  assign accept      = instr_valid && instr_ready;
  assign rf_rd_addr1 = instr_rs1;
  assign rf_rd_addr2 = instr_rs2;

  // Younger wb result beats the last-write register, which covers the read-first miss.
  function automatic logic [DATA_WIDTH-1:0] fwd(input logic [REG_WIDTH-1:0]  rs,
                                                input logic [DATA_WIDTH-1:0] rf_data);
    if (wb_valid && wb_wen && (wb_rd == rs))
      return wb_data;
    else if (lw_valid && (lw_addr == rs))
      return lw_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    op_a  = fwd(s1.rs1, rf_rd_data1);
    op_b  = fwd(s1.rs2, rf_rd_data2);
    alu_b = (s1.op == OP_LDI) ? s1.imm : op_b;
  end

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (s1.op),
    .a      (op_a),
    .b      (alu_b),
    .result (alu_res)
  );

  // Writes are suppressed while rst is low so an in-flight result never lands on the reset edge.
  always_comb begin
    if (state == ST_INIT) begin
      rf_wen     = rst;
      rf_wr_addr = init_cnt;
      rf_wr_data = '0;
    end else begin
      rf_wen     = rst && wb_valid && wb_wen;
      rf_wr_addr = wb_rd;
      rf_wr_data = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      s1_valid <= 1'b0;
      s1       <= '0;
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      lw_valid <= 1'b0;
      lw_addr  <= '0;
      lw_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1 <= '{op: instr_op, rd: instr_rd, rs1: instr_rs1, rs2: instr_rs2, imm: instr_imm};
      end

      wb_valid <= s1_valid;
      wb_wen   <= s1_valid && (s1.op != OP_NOP);
      wb_rd    <= s1.rd;
      wb_data  <= alu_res;

      lw_valid <= (state == ST_RUN) && rf_wen;
      lw_addr  <= wb_rd;
      lw_data  <= wb_data;

      if (state == ST_INIT) begin
        init_cnt <= init_cnt + {{(REG_WIDTH-1){1'b0}}, 1'b1};
        if (init_cnt == {REG_WIDTH{1'b1}}) begin
          state <= ST_RUN;
        end
      end
    end
  end

endmodule
